// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
// The presets are also used by the counter's load input.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_LAP,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [3:0]  ERR_NONE   = 4'd0;
    localparam logic [3:0]  ERR_CFG    = 4'd1;
    localparam logic [3:0]  ERR_OVF    = 4'd2;

    localparam logic [15:0] PRESET_SEC = 16'h0030;
    localparam logic [15:0] PRESET_MIN = 16'h0500;
    localparam logic [15:0] OVF_VALUE  = 16'h5959;

    function automatic logic [15:0] err_pattern(input logic [3:0] code);
        return {8'hEE, 4'h0, code};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any glitch back to the accepted level restarts it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: turns button presses and mode DIPs into
// registered counter strobes, lap hold and error display control.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        MAINCLOCK,
    input  logic        MAINRESETN,
    input  logic        TICK1S,
    input  logic        BTN_START,
    input  logic        BTN_LAP,
    input  logic        DIP_SEC,
    input  logic        DIP_MIN,
    input  logic [15:0] MCOUNT,
    output logic        CNT_STEP,
    output logic        CNT_DOWN,
    output logic        CNT_LOAD,
    output logic        CNT_CLR,
    output logic        LAP_HOLD,
    output logic        ERR,
    output logic [15:0] ERR_DIGITS
);

    logic start_press, lap_press;
    logic start_ev, lap_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk_i(MAINCLOCK), .rst_ni(MAINRESETN), .btn_i(BTN_START), .press_o(start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk_i(MAINCLOCK), .rst_ni(MAINRESETN), .btn_i(BTN_LAP), .press_o(lap_press)
    );

    // START has priority; a coincident LAP press is discarded.
    assign start_ev = start_press;
    assign lap_ev   = lap_press & ~start_press;

    state_e     state_q, state_d;
    logic       step_q, step_d, load_q, load_d, clr_q, clr_d;
    logic       down_q, down_d, hold_q, hold_d, err_q, err_d;
    logic [3:0] code_q, code_d;
    logic       counting, cfg_bad, countdown_sel, at_zero, at_ovf;

    assign counting      = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign cfg_bad       = DIP_SEC & DIP_MIN;
    assign countdown_sel = DIP_SEC | DIP_MIN;
    assign at_zero       = down_q && (MCOUNT == 16'h0000);
    assign at_ovf        = !down_q && TICK1S && (MCOUNT == OVF_VALUE);

    always_ff @(posedge MAINCLOCK or negedge MAINRESETN) begin
        if (!MAINRESETN) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_ev) state_d = cfg_bad ? ST_ERROR : ST_RUN;
            ST_RUN: begin
                if      (start_ev) state_d = ST_PAUSE;
                else if (lap_ev)   state_d = ST_LAP;
                else if (at_zero)  state_d = ST_DONE;
                else if (at_ovf)   state_d = ST_ERROR;
            end
            ST_LAP: begin
                if      (start_ev) state_d = ST_PAUSE;
                else if (lap_ev)   state_d = ST_RUN;
                else if (at_zero)  state_d = ST_DONE;
                else if (at_ovf)   state_d = ST_ERROR;
            end
            ST_PAUSE: begin
                if      (start_ev) state_d = ST_RUN;
                else if (lap_ev)   state_d = ST_IDLE;
            end
            ST_DONE, ST_ERROR: if (start_ev || lap_ev) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Steps at zero (countdown) or at 59:59 (up) are suppressed so the counter never wraps.
    always_comb begin
        step_d = TICK1S && counting && !at_zero && !at_ovf;
        load_d = 1'b0;
        clr_d  = 1'b0;
        down_d = down_q;
        code_d = code_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ev && cfg_bad) begin
                    code_d = ERR_CFG;
                end else if (start_ev) begin
                    load_d = countdown_sel;
                    clr_d  = !countdown_sel;
                    down_d = countdown_sel;
                end else if (lap_ev) begin
                    clr_d = 1'b1;
                end
            end
            ST_RUN, ST_LAP: if (state_d == ST_ERROR) code_d = ERR_OVF;
            ST_PAUSE:       clr_d = lap_ev;
            ST_DONE:        clr_d = start_ev || lap_ev;
            ST_ERROR: begin
                if (start_ev || lap_ev) begin
                    clr_d  = 1'b1;
                    code_d = ERR_NONE;
                end
            end
            default: ;
        endcase
        hold_d = (state_d == ST_LAP);
        err_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge MAINCLOCK or negedge MAINRESETN) begin
        if (!MAINRESETN) begin
            step_q <= 1'b0;
            load_q <= 1'b0;
            clr_q  <= 1'b0;
            down_q <= 1'b0;
            hold_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
        end else begin
            step_q <= step_d;
            load_q <= load_d;
            clr_q  <= clr_d;
            down_q <= down_d;
            hold_q <= hold_d;
            err_q  <= err_d;
            code_q <= code_d;
        end
    end

    assign CNT_STEP   = step_q;
    assign CNT_LOAD   = load_q;
    assign CNT_CLR    = clr_q;
    assign CNT_DOWN   = down_q;
    assign LAP_HOLD   = hold_q;
    assign ERR        = err_q;
    assign ERR_DIGITS = err_pattern(code_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: button sequences, ticks and MCOUNT
// values with hand-computed expected strobes and flags.
module tb_stopwatch_ctrl;

    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tick = 1'b0;
    logic        bs = 1'b0;
    logic        bl = 1'b0;
    logic        dsec = 1'b0;
    logic        dmin = 1'b0;
    logic [15:0] mcount = 16'h0100;

    logic        CNT_STEP, CNT_DOWN, CNT_LOAD, CNT_CLR, LAP_HOLD, ERR;
    logic [15:0] ERR_DIGITS;

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int load_cnt = 0;
    int step_cnt = 0;
    int wide_cnt = 0;
    logic clr_prev = 1'b0;
    logic load_prev = 1'b0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .MAINCLOCK (clk),
        .MAINRESETN(rstn),
        .TICK1S    (tick),
        .BTN_START (bs),
        .BTN_LAP   (bl),
        .DIP_SEC   (dsec),
        .DIP_MIN   (dmin),
        .MCOUNT    (mcount),
        .CNT_STEP  (CNT_STEP),
        .CNT_DOWN  (CNT_DOWN),
        .CNT_LOAD  (CNT_LOAD),
        .CNT_CLR   (CNT_CLR),
        .LAP_HOLD  (LAP_HOLD),
        .ERR       (ERR),
        .ERR_DIGITS(ERR_DIGITS)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (CNT_CLR)  clr_cnt  <= clr_cnt + 1;
        if (CNT_LOAD) load_cnt <= load_cnt + 1;
        if (CNT_STEP) step_cnt <= step_cnt + 1;
        if ((CNT_CLR && clr_prev) || (CNT_LOAD && load_prev)) wide_cnt <= wide_cnt + 1;
        clr_prev  <= CNT_CLR;
        load_prev <= CNT_LOAD;
    end

    task automatic press(input logic s, input logic l);
        @(negedge clk);
        bs = s;
        bl = l;
        repeat (DB + 4) @(negedge clk);
        bs = 1'b0;
        bl = 1'b0;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic do_tick(output logic stepped);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #1 stepped = CNT_STEP;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (CNT_STEP !== 1'b0) begin errors++; $display("FAIL rst_step got %b want 0", CNT_STEP); end
        checks++; if (CNT_LOAD !== 1'b0) begin errors++; $display("FAIL rst_load got %b want 0", CNT_LOAD); end
        checks++; if (CNT_CLR !== 1'b0) begin errors++; $display("FAIL rst_clr got %b want 0", CNT_CLR); end
        checks++; if (CNT_DOWN !== 1'b0) begin errors++; $display("FAIL rst_down got %b want 0", CNT_DOWN); end
        checks++; if (LAP_HOLD !== 1'b0) begin errors++; $display("FAIL rst_hold got %b want 0", LAP_HOLD); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", ERR); end
        checks++; if (ERR_DIGITS !== 16'hEE00) begin errors++; $display("FAIL rst_digits got %h want EE00", ERR_DIGITS); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_up_run;
        int c0, l0;
        logic s;
        dsec = 1'b0; dmin = 1'b0; mcount = 16'h0100;
        c0 = clr_cnt; l0 = load_cnt;
        press(1'b1, 1'b0);
        checks++; if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL up_start_clr got %0d want 1", clr_cnt - c0); end
        checks++; if (load_cnt - l0 !== 0) begin errors++; $display("FAIL up_start_load got %0d want 0", load_cnt - l0); end
        checks++; if (CNT_DOWN !== 1'b0) begin errors++; $display("FAIL up_down got %b want 0", CNT_DOWN); end
        for (int i = 0; i < 5; i++) begin
            do_tick(s);
            checks++; if (s !== 1'b1) begin errors++; $display("FAIL up_step%0d got %b want 1", i, s); end
            @(negedge clk);
            #1;
            checks++; if (CNT_STEP !== 1'b0) begin errors++; $display("FAIL up_step_width%0d got %b want 0", i, CNT_STEP); end
        end
    endtask

    task automatic test_reset_mid;
        logic s;
        @(negedge clk);
        tick = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++; if ({CNT_STEP, CNT_LOAD, CNT_CLR, CNT_DOWN, LAP_HOLD, ERR} !== 6'b0) begin
            errors++; $display("FAIL mid_rst_flags got %b want 000000", {CNT_STEP, CNT_LOAD, CNT_CLR, CNT_DOWN, LAP_HOLD, ERR}); end
        @(negedge clk);
        tick = 1'b0;
        #1;
        checks++; if (CNT_STEP !== 1'b0) begin errors++; $display("FAIL mid_rst_step got %b want 0", CNT_STEP); end
        checks++; if (ERR_DIGITS !== 16'hEE00) begin errors++; $display("FAIL mid_rst_digits got %h want EE00", ERR_DIGITS); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        do_tick(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL mid_rst_idle_step got %b want 0", s); end
    endtask

    task automatic test_countdown;
        int c0, l0, s0;
        logic s;
        dsec = 1'b1; mcount = 16'h0030;
        c0 = clr_cnt; l0 = load_cnt;
        press(1'b1, 1'b0);
        checks++; if (load_cnt - l0 !== 1) begin errors++; $display("FAIL cd_load got %0d want 1", load_cnt - l0); end
        checks++; if (clr_cnt - c0 !== 0) begin errors++; $display("FAIL cd_clr got %0d want 0", clr_cnt - c0); end
        checks++; if (CNT_DOWN !== 1'b1) begin errors++; $display("FAIL cd_down got %b want 1", CNT_DOWN); end
        do_tick(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL cd_step got %b want 1", s); end
        mcount = 16'h0000;
        repeat (2) @(negedge clk);
        s0 = step_cnt;
        do_tick(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL cd_done_step got %b want 0", s); end
        do_tick(s);
        repeat (2) @(negedge clk);
        checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL cd_done_steps got %0d want 0", step_cnt - s0); end
        c0 = clr_cnt;
        press(1'b0, 1'b1);
        checks++; if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL cd_lap_clr got %0d want 1", clr_cnt - c0); end
        dsec = 1'b0;
        do_tick(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL cd_idle_step got %b want 0", s); end
        mcount = 16'h0100;
    endtask

    task automatic test_cfg_err;
        int c0, l0;
        logic s;
        dsec = 1'b1; dmin = 1'b1;
        c0 = clr_cnt; l0 = load_cnt;
        press(1'b1, 1'b0);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL cfg_err got %b want 1", ERR); end
        checks++; if (ERR_DIGITS !== 16'hEE01) begin errors++; $display("FAIL cfg_digits got %h want EE01", ERR_DIGITS); end
        checks++; if ((clr_cnt - c0) + (load_cnt - l0) !== 0) begin
            errors++; $display("FAIL cfg_strobes got %0d want 0", (clr_cnt - c0) + (load_cnt - l0)); end
        do_tick(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL cfg_step got %b want 0", s); end
        dsec = 1'b0; dmin = 1'b0;
        c0 = clr_cnt;
        press(1'b1, 1'b0);
        checks++; if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL cfg_exit_clr got %0d want 1", clr_cnt - c0); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL cfg_exit_err got %b want 0", ERR); end
        checks++; if (ERR_DIGITS !== 16'hEE00) begin errors++; $display("FAIL cfg_exit_digits got %h want EE00", ERR_DIGITS); end
    endtask

    task automatic test_overflow;
        int c0;
        logic s;
        mcount = 16'h0100;
        press(1'b1, 1'b0);
        mcount = 16'h5959;
        do_tick(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL ovf_wrap_step got %b want 0", s); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", ERR); end
        checks++; if (ERR_DIGITS !== 16'hEE02) begin errors++; $display("FAIL ovf_digits got %h want EE02", ERR_DIGITS); end
        do_tick(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL ovf_after_step got %b want 0", s); end
        c0 = clr_cnt;
        press(1'b0, 1'b1);
        checks++; if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL ovf_exit_clr got %0d want 1", clr_cnt - c0); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL ovf_exit_err got %b want 0", ERR); end
        mcount = 16'h0100;
    endtask

    task automatic test_lap_pause;
        logic s;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        checks++; if (LAP_HOLD !== 1'b1) begin errors++; $display("FAIL lap_hold_on got %b want 1", LAP_HOLD); end
        do_tick(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL lap_step got %b want 1", s); end
        press(1'b0, 1'b1);
        checks++; if (LAP_HOLD !== 1'b0) begin errors++; $display("FAIL lap_hold_off got %b want 0", LAP_HOLD); end
        do_tick(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL lap_run_step got %b want 1", s); end
        press(1'b1, 1'b0);
        do_tick(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL pause_step got %b want 0", s); end
        press(1'b1, 1'b0);
        do_tick(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL resume_step got %b want 1", s); end
    endtask

    task automatic test_bounce_simul;
        int c0;
        logic s;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bs = 1'b1;
            repeat (DB / 2) @(negedge clk);
            bs = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (DB + 4) @(negedge clk);
        do_tick(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL bounce_still_run got %b want 1", s); end
        c0 = clr_cnt;
        press(1'b1, 1'b1);
        checks++; if (LAP_HOLD !== 1'b0) begin errors++; $display("FAIL simul_hold got %b want 0", LAP_HOLD); end
        do_tick(s);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL simul_pause_step got %b want 0", s); end
        press(1'b1, 1'b0);
        do_tick(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL simul_resume_step got %b want 1", s); end
        checks++; if (clr_cnt - c0 !== 0) begin errors++; $display("FAIL simul_clr got %0d want 0", clr_cnt - c0); end
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_reset_mid();
        test_countdown();
        test_cfg_err();
        test_overflow();
        test_lap_pause();
        test_bounce_simul();
        checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_width got %0d wide strobes want 0", wide_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch datapath. It turns debounced push-button presses and DIP mode switches into counter-control strobes: step, load, clear and direction. It also detects terminal/overflow conditions and drives the error flag and error digits consumed by the display selector. It sits between the 1 s clock divider and the min/sec counter, and replaces ad-hoc gating of counter enables.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable MAINCLOCK cycles for a button press to register (set to 1_000_000 on board)
- MAINCLOCK  in  1  system clock; all logic on rising edge
- MAINRESETN  in  1  asynchronous, active-low reset
- TICK1S  in  1  one-MAINCLOCK-cycle pulse per second from the clock divider
- BTN_START  in  1  raw start/stop push button, active-high
- BTN_LAP  in  1  raw lap/clear push button, active-high
- DIP_SEC  in  1  countdown-seconds preset select
- DIP_MIN  in  1  countdown-minutes preset select
- MCOUNT  in  16  current counter value, 4 BCD digits {M1,M0,S1,S0}
- CNT_STEP  out  1  one-cycle count strobe to the counter
- CNT_DOWN  out  1  1 = count down, 0 = count up
- CNT_LOAD  out  1  one-cycle preset load strobe
- CNT_CLR  out  1  one-cycle synchronous clear strobe
- LAP_HOLD  out  1  display freezes the last value while high
- ERR  out  1  display selects ERR_DIGITS while high
- ERR_DIGITS  out  16  error pattern {4'hE, 4'hE, 4'h0, code}

## Operation
- Buttons pass through a debouncer and produce one press pulse per stable rising level. There is no repeat while held.
- Mode is sampled only in IDLE:
  - DIP_SEC=DIP_MIN=0: count up.
  - DIP_SEC=1 only: count down from preset 00:30.
  - DIP_MIN=1 only: count down from preset 05:00.
  - Both high: config error.
- States are IDLE, RUN, PAUSE, LAP, DONE, ERROR.
- IDLE:
  - START with valid mode: pulse CNT_LOAD (countdown) or CNT_CLR (up), latch CNT_DOWN, go to RUN.
  - START with both DIPs high: go to ERROR, code 1.
  - LAP: pulse CNT_CLR, stay in IDLE.
- RUN:
  - START: go to PAUSE.
  - LAP: go to LAP.
  - Countdown with MCOUNT==16'h0000: go to DONE.
  - Up mode with a step at MCOUNT==16'h5959: go to ERROR, code 2. No wrap.
- LAP: counting continues and LAP_HOLD=1. LAP returns to RUN. START goes to PAUSE, and LAP_HOLD drops.
- PAUSE: START returns to RUN. LAP pulses CNT_CLR and goes to IDLE.
- DONE: no stepping. START or LAP pulses CNT_CLR and goes to IDLE.
- ERROR: ERR=1 and no stepping. START or LAP pulses CNT_CLR, clears ERR and goes to IDLE.
- Error codes: 1 = invalid DIP combination, 2 = up-count overflow. ERR_DIGITS is 16'hEE00 when no error is latched.
- CNT_STEP = TICK1S registered, gated by the current state being RUN or LAP. A tick arriving in the same cycle as the transition out of RUN is still counted.
- Simultaneous START and LAP pulses: START wins and LAP is dropped.

## Timing
- Reset values:
  - state IDLE
  - all strobes 0
  - CNT_DOWN 0
  - LAP_HOLD 0
  - ERR 0
  - ERR_DIGITS 16'hEE00
  - debouncer counters 0
- Button to press pulse: DEBOUNCE_CYCLES+2 cycles (2-flop synchroniser plus stability count). The pulse to the state change and output strobe adds 1 cycle; all outputs are registered.
- CNT_STEP asserts 1 cycle after TICK1S.
- CNT_LOAD and CNT_CLR are exactly 1 cycle wide.
- The zero/overflow check uses MCOUNT sampled in the same cycle as the decision. The counter updates MCOUNT 1 cycle after CNT_STEP, so DONE is entered at most 2 cycles after the last step.
- A reset asserted mid-operation forces reset values immediately, with no strobe emitted. Deassertion is synchronised by the top level.

## Structure
- Package stopwatch_pkg holds:
  - the state enum
  - error code constants (ERR_NONE=0, ERR_CFG=1, ERR_OVF=2)
  - preset constants PRESET_SEC=16'h0030 and PRESET_MIN=16'h0500
  - OVF_VALUE=16'h5959
- Presets are exported for the counter's load input.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES) contains the synchroniser, stability counter and rising-edge pulse. It is instantiated twice.

## Test plan
- Reset mid-RUN, then release: all outputs at reset values. START (held DEBOUNCE_CYCLES+4) → CNT_CLR pulse, CNT_DOWN=0, state RUN. Five TICK1S pulses → five CNT_STEP pulses, each 1 cycle late.
- DIP_SEC=1, START → CNT_LOAD pulse and CNT_DOWN=1. Drive MCOUNT=16'h0000 → DONE, no further CNT_STEP. LAP → CNT_CLR, then IDLE.
- DIP_SEC=DIP_MIN=1, START → ERR=1, ERR_DIGITS=16'hEE01, no CNT_STEP on ticks. START → CNT_CLR, ERR=0.
- Up mode, MCOUNT=16'h5959, TICK1S → ERR=1, ERR_DIGITS=16'hEE02, no wrap step afterwards.
- RUN, LAP → LAP_HOLD=1 with steps continuing. LAP → LAP_HOLD=0. START → PAUSE, no steps. START → RUN.
- Button bounce shorter than DEBOUNCE_CYCLES → no pulse. START and LAP pressed the same cycle in RUN → PAUSE, LAP_HOLD stays 0.
